// File: rtl/sum_adder_pkg.sv
// -----------------------------------------------------------------------------
// sum_adder_pkg
//   Shared definitions for the sum-adder controller and its datapath:
//   the width of N and the 2-bit encoding of the controller states.
// -----------------------------------------------------------------------------
package sum_adder_pkg;

  // Width of N, matching inBus.
  localparam int N_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_INIT  = 2'd1;
  localparam state_t S_ACCUM = 2'd2;
  localparam state_t S_DONE  = 2'd3;

endpackage : sum_adder_pkg

// File: rtl/sum_adder_ctrl.sv
// -----------------------------------------------------------------------------
// sum_adder_ctrl
//   Sequencer for the sum-adder datapath that computes S = 0+1+...+N.
//   States IDLE -> INIT -> ACCUM (N+1 cycles) -> DONE -> IDLE.
//
//   Optional feature macro: SUM_CTRL_WATCHDOG_EN
//     When defined, a WDOG_W-bit counter bounds the ACCUM phase to WDOG_LIMIT
//     cycles; on expiry the run is abandoned and the sticky wdogErr is set.
//     When undefined, wdogErr is tied low and ACCUM waits for nEqual forever.
//
// Ports
//   clk         in  system clock, rising edge
//   rst         in  synchronous active-high reset
//   start       in  run request (inBus carries N in the same cycle)
//   nEqual      in  datapath counter == N
//   NregEn      out load N register (IDLE and start)
//   counterInit out counter <= 0 (INIT)
//   counterEn   out counter <= counter + 1 (ACCUM while counter != N)
//   sumRegEn    out sumReg <= sumReg + counter (ACCUM)
//   sumClr      out clear sumReg (INIT)
//   busy        out high in INIT/ACCUM/DONE
//   done        out one-cycle pulse, dataOut valid in this cycle
//   resultValid out level, set leaving DONE, cleared by accepted start or rst
//   wdogErr     out sticky watchdog abort flag
// -----------------------------------------------------------------------------
module sum_adder_ctrl
    import sum_adder_pkg::*;
#(
    parameter int WDOG_W     = 10,
    parameter int WDOG_LIMIT = 300
)
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic nEqual,
    output logic NregEn,
    output logic counterInit,
    output logic counterEn,
    output logic sumRegEn,
    output logic sumClr,
    output logic busy,
    output logic done,
    output logic resultValid,
    output logic wdogErr
);

    state_t state_q, state_d;
    logic   result_valid_q, result_valid_d;

`ifdef SUM_CTRL_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
`ifdef SUM_CTRL_WATCHDOG_EN
            wdog_cnt_q     <= '0;
            wdog_err_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
`ifdef SUM_CTRL_WATCHDOG_EN
            wdog_cnt_q     <= wdog_cnt_d;
            wdog_err_q     <= wdog_err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        result_valid_d = result_valid_q;
`ifdef SUM_CTRL_WATCHDOG_EN
        wdog_cnt_d     = wdog_cnt_q;
        wdog_err_d     = wdog_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_INIT;
                    result_valid_d = 1'b0;
                end
            end
            S_INIT: begin
                state_d = S_ACCUM;
`ifdef SUM_CTRL_WATCHDOG_EN
                wdog_cnt_d = '0;
`endif
            end
            S_ACCUM: begin
`ifdef SUM_CTRL_WATCHDOG_EN
                wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
`endif
                if (nEqual) begin
                    state_d = S_DONE;
                end
`ifdef SUM_CTRL_WATCHDOG_EN
                // The count holds the number of ACCUM cycles already spent, so
                // this is the WDOG_LIMIT-th ACCUM cycle without reaching N.
                else if (wdog_cnt_q == WDOG_W'(WDOG_LIMIT - 1)) begin
                    state_d    = S_IDLE;
                    wdog_err_d = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d        = S_IDLE;
                result_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (NregEn is Mealy on start; everything else is Moore)
    // -------------------------------------------------------------------------
    always_comb begin
        NregEn      = 1'b0;
        counterInit = 1'b0;
        counterEn   = 1'b0;
        sumRegEn    = 1'b0;
        sumClr      = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE:  NregEn = start;
            S_INIT: begin
                counterInit = 1'b1;
                sumClr      = 1'b1;
            end
            S_ACCUM: begin
                sumRegEn  = 1'b1;
                // Stop counting on the last add so the counter rests at N.
                counterEn = ~nEqual;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign resultValid = result_valid_q;

`ifdef SUM_CTRL_WATCHDOG_EN
    assign wdogErr = wdog_err_q;
`else
    assign wdogErr = 1'b0;
`endif

endmodule : sum_adder_ctrl
